// File: rtl/sreg_sipo_pkg.sv
// Shared types and sizes for the word-serial to parallel shift register.
package sreg_sipo_pkg;

  localparam int SIPO_N_IN  = 9;
  localparam int SIPO_WIDTH = 16;

  // Enough bits to count 0..SIPO_N_IN inclusive.
  localparam int SIPO_FILL_W = $clog2(SIPO_N_IN + 1);

  typedef logic [SIPO_WIDTH-1:0] word_t;
  typedef word_t [SIPO_N_IN-1:0] chain_t;

endpackage

// File: rtl/sreg_word_stage.sv
// One WIDTH-bit register with asynchronous active-low clear.
module sreg_word_stage
  import sreg_sipo_pkg::*;
(
  input  logic  clk,
  input  logic  rst_n,
  input  word_t word_d,
  output word_t word_q
);

  // Plain word register; clears immediately when rst_n falls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word_q <= '0;
    end else begin
      word_q <= word_d;
    end
  end

endmodule

// File: rtl/sreg_sipo_9x16.sv
// Serial-in/parallel-out word shift register: 9 words of 16 bits.
// A new word enters at word 8 every clock; load copies the pre-edge chain
// into the held parallel output. Optional fill tracking and out_valid are
// compiled in with SREG_SIPO_VALID_EN.
module sreg_sipo_9x16
  import sreg_sipo_pkg::*;
(
  input  logic                           clk,
  input  logic                           rst,
  input  logic [SIPO_WIDTH-1:0]          in_serial,
  input  logic                           load,
`ifdef SREG_SIPO_VALID_EN
  output logic                           out_valid,
`endif
  output logic [SIPO_N_IN*SIPO_WIDTH-1:0] out_parallel
);

  chain_t chain_d;
  chain_t chain_q;
  chain_t out_d;
  chain_t out_q;

  // Next chain shifts toward word 0; next output recaptures only on load.
  always_comb begin
    chain_d = {in_serial, chain_q[SIPO_N_IN-1:1]};
    out_d   = load ? chain_q : out_q;
  end

  for (genvar i = 0; i < SIPO_N_IN; i++) begin : g_chain
    sreg_word_stage u_stage (
      .clk    (clk),
      .rst_n  (rst),
      .word_d (chain_d[i]),
      .word_q (chain_q[i])
    );
  end

  for (genvar i = 0; i < SIPO_N_IN; i++) begin : g_out
    sreg_word_stage u_stage (
      .clk    (clk),
      .rst_n  (rst),
      .word_d (out_d[i]),
      .word_q (out_q[i])
    );
  end

  assign out_parallel = out_q;

`ifdef SREG_SIPO_VALID_EN
  logic [SIPO_FILL_W-1:0] fill_d;
  logic [SIPO_FILL_W-1:0] fill_q;
  logic                   valid_d;
  logic                   valid_q;
  logic                   full;

  // Fill count saturates at N_IN; a load restarts it and ignores that edge's word.
  always_comb begin
    full    = (fill_q == SIPO_FILL_W'(SIPO_N_IN));
    fill_d  = fill_q;
    valid_d = valid_q;
    if (load) begin
      fill_d  = '0;
      valid_d = full;
    end else if (!full) begin
      fill_d  = fill_q + 1'b1;
    end
  end

  // Fill counter and valid flag registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fill_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      fill_q  <= fill_d;
      valid_q <= valid_d;
    end
  end

  assign out_valid = valid_q;
`endif

endmodule

// File: tb/tb_sreg_sipo_9x16.sv
// Self-checking bench for sreg_sipo_9x16 (directed table, corner sequences,
// random traffic against a history-based reference model).
module tb_sreg_sipo_9x16;
  import sreg_sipo_pkg::*;

  logic                            clk;
  logic                            rst;
  word_t                           in_serial;
  logic                            load;
  logic [SIPO_N_IN*SIPO_WIDTH-1:0] out_parallel;
`ifdef SREG_SIPO_VALID_EN
  logic                            out_valid;
`endif

  int compared   = 0;
  int mismatched = 0;

  sreg_sipo_9x16 dut (
    .clk          (clk),
    .rst          (rst),
    .in_serial    (in_serial),
    .load         (load),
`ifdef SREG_SIPO_VALID_EN
    .out_valid    (out_valid),
`endif
    .out_parallel (out_parallel)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: every word shifted since reset, and shifts since last load.
  word_t  hist[$];
  int     since_load;
  chain_t m_out;
  logic   m_valid;

  task automatic model_reset();
    hist.delete();
    since_load = 0;
    m_out      = '0;
    m_valid    = 1'b0;
  endtask

  task automatic model_edge(input word_t din, input logic ld);
    if (ld) begin
      for (int k = 0; k < SIPO_N_IN; k++) begin
        int idx;
        idx = hist.size() - SIPO_N_IN + k;
        m_out[k] = (idx >= 0) ? hist[idx] : '0;
      end
      m_valid    = (since_load >= SIPO_N_IN);
      since_load = 0;
    end else begin
      since_load++;
    end
    hist.push_back(din);
    if (hist.size() > SIPO_N_IN) void'(hist.pop_front());
  endtask

  task automatic cmp_out(input string name, input chain_t exp);
    compared++;
    if (out_parallel !== exp) begin
      mismatched++;
      $display("FAIL %s: out_parallel got %h expected %h", name, out_parallel, exp);
    end
  endtask

  task automatic cmp_valid(input string name, input logic exp);
`ifdef SREG_SIPO_VALID_EN
    compared++;
    if (out_valid !== exp) begin
      mismatched++;
      $display("FAIL %s: out_valid got %b expected %b", name, out_valid, exp);
    end
`endif
  endtask

  task automatic cmp_word(input string name, input int k, input word_t exp);
    chain_t img;
    img = out_parallel;
    compared++;
    if (img[k] !== exp) begin
      mismatched++;
      $display("FAIL %s: word %0d got %h expected %h", name, k, img[k], exp);
    end
  endtask

  // One clock: drive, clock, update model, compare just after the edge.
  task automatic step(input string name, input word_t din, input logic ld);
    in_serial = din;
    load      = ld;
    @(posedge clk);
    model_edge(din, ld);
    #1;
    cmp_out(name, m_out);
    cmp_valid(name, m_valid);
  endtask

  typedef struct {
    word_t  din;
    logic   ld;
    chain_t exp;
    logic   exp_valid;
  } vec_t;

  vec_t vecs[20];

  initial begin
    chain_t pat;
    chain_t all_a;
    word_t  fill_seq[9];
    word_t  new_w[5];
    pat      = {16'h0, 16'h1, 16'h0, 16'h0, 16'h1, 16'h0, 16'h1, 16'h0, 16'h1};
    all_a    = {SIPO_N_IN{16'hAAAA}};
    fill_seq = '{16'h1, 16'h0, 16'h1, 16'h0, 16'h1, 16'h0, 16'h0, 16'h1, 16'h0};
    for (int i = 0; i < 9; i++) vecs[i] = '{fill_seq[i], 1'b0, '0, 1'b0};
    vecs[9] = '{16'h1234, 1'b1, pat, 1'b1};
    for (int i = 10; i < 19; i++) vecs[i] = '{16'hAAAA, 1'b0, pat, 1'b1};
    vecs[19] = '{16'h5555, 1'b1, all_a, 1'b1};

    // Reset held with a running clock and hostile inputs.
    rst = 1'b0; in_serial = 16'hFFFF; load = 1'b1;
    model_reset();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      cmp_out("reset_hold", '0);
      cmp_valid("reset_hold", 1'b0);
    end
    @(negedge clk);
    rst = 1'b1; load = 1'b0;

    // Directed table: fill, capture, hold, recapture.
    for (int i = 0; i < 20; i++) begin
      in_serial = vecs[i].din;
      load      = vecs[i].ld;
      @(posedge clk);
      model_edge(vecs[i].din, vecs[i].ld);
      #1;
      cmp_out($sformatf("table_%0d", i), vecs[i].exp);
      cmp_valid($sformatf("table_%0d", i), vecs[i].exp_valid);
      cmp_out($sformatf("table_model_%0d", i), m_out);
    end

    // Sliding window: load held while shifting 1..12, then one more edge.
    for (int v = 1; v <= 12; v++) step("slide", word_t'(v), 1'b1);
    step("slide_last", 16'h0000, 1'b1);
    cmp_word("slide_w8", 8, 16'h000C);
    cmp_word("slide_w0", 0, 16'h0004);

    // Fill the chain, then drop reset between edges.
    for (int i = 0; i < 9; i++) step("prefill", word_t'($urandom), 1'b0);
    step("prefill_load", word_t'($urandom), 1'b1);
    #2;
    rst = 1'b0;
    #1;
    model_reset();
    cmp_out("async_rst", '0);
    cmp_valid("async_rst", 1'b0);
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      new_w[i] = word_t'($urandom);
      step("post_rst", new_w[i], 1'b0);
    end
    step("post_rst_load", 16'hBEEF, 1'b1);
    cmp_valid("post_rst_valid", 1'b0);
    for (int i = 0; i < 3; i++) cmp_word("post_rst_word", 6 + i, new_w[i]);
    cmp_word("post_rst_w5", 5, 16'h0000);

    // Early load: 5 shifts after a load.
    for (int i = 0; i < 5; i++) begin
      new_w[i] = word_t'($urandom);
      step("early", new_w[i], 1'b0);
    end
    step("early_load", 16'h7777, 1'b1);
    cmp_valid("early_valid", 1'b0);
    for (int i = 0; i < 5; i++) cmp_word("early_word", 4 + i, new_w[i]);
    cmp_word("early_w3", 3, 16'hBEEF);

    // Random traffic.
    for (int i = 0; i < 300; i++) begin
      step("random", word_t'($urandom), ($urandom_range(0, 3) == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
